uart_tx_arbiter: RTL

Packet-level round-robin arbiter that shares a single `uart_tx` serializer among `NUM_REQ` byte-stream requesters. A grant covers one whole packet: the owning requester's bytes go to the UART back to back, with no interleaving, until its `req_last` byte has fully left the line. The block sits directly in front of `uart_tx`. It drives that module's `tx_start`/`tx_data` and sequences on its `tx_busy`.

---
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin front end for one uart_tx.
// Optional stall timeout is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [IDW-1:0]       grant_id,
  output logic                 timeout_pulse
);

  typedef enum logic [1:0] {
    ARB,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [IDW-1:0] ptr_q;
  logic           last_q;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;

  logic           sel_valid;
  logic           sel_last;
  logic [7:0]     sel_data;

  logic           xfer;
  logic           grant;
  logic           rel;
  logic           revoke;

  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = req_data[{grant_id, 3'b000} +: 8];

  // Round-robin search: first valid requester above the last winner.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] stall_q;

  // Stall counter: counts idle SEND cycles, cleared per byte and outside SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q != SEND || xfer) begin
      stall_q <= '0;
    end else if (!sel_valid) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign revoke = (state_q == SEND) &&
                  (stall_q == 16'(TIMEOUT_CYCLES));
`else
  assign revoke = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake and grant control strobes.
  always_comb begin
    state_d       = state_q;
    req_ready     = '0;
    timeout_pulse = 1'b0;
    xfer          = 1'b0;
    grant         = 1'b0;
    rel           = 1'b0;
    unique case (state_q)
      ARB: begin
        if (win_found) begin
          grant   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (revoke) begin
          timeout_pulse = 1'b1;
          rel           = 1'b1;
          state_d       = ARB;
        end else begin
          req_ready[grant_id] = 1'b1;
          if (sel_valid) begin
            xfer    = 1'b1;
            state_d = WAIT_BUSY;
          end
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            rel     = 1'b1;
            state_d = ARB;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // Registered UART drive, grant bookkeeping and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      last_q       <= 1'b0;
      grant_active <= 1'b0;
      grant_id     <= '0;
      ptr_q        <= IDW'(NUM_REQ - 1);
    end else begin
      tx_start <= xfer;
      if (xfer) begin
        tx_data <= sel_data;
        last_q  <= sel_last;
      end
      if (grant) begin
        grant_active <= 1'b1;
        grant_id     <= win_id;
        ptr_q        <= win_id;
      end else if (rel) begin
        grant_active <= 1'b0;
      end
    end
  end

endmodule
